sram_arbiter: RTL
=================

# sram_arbiter

Round-robin arbiter that shares the single off-chip SRAM controller between up to NUM_REQ client blocks (audio recorder, letter recogniser, display reader). It sits between the clients and the SRAM controller's core port. It accepts one transaction at a time, issues it downstream, and tracks completion through the controller's wait signal. It returns read data, or a timeout error, to the granted client only.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- TIMEOUT, 64, max cycles in GUARD+BUSY before abort (>=4)

Ports (reset i_rst, asynchronous, active-low; clock i_clk):
- i_clk  in  1  clock
- i_rst  in  1  async active-low reset
- i_req  in  NUM_REQ  per-client request; level, held until o_gnt
- i_wr  in  NUM_REQ  per-client direction, 1 = write
- i_addr  in  NUM_REQ*ADDR_W  packed addresses, client k at [k*ADDR_W +: ADDR_W]
- i_wdata  in  NUM_REQ*DATA_W  packed write data
- o_gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- o_done  out  NUM_REQ  one-hot, one-cycle completion pulse
- o_err  out  1  high with o_done when the transaction timed out
- o_rdata  out  DATA_W  read data; valid while o_done is high
- o_busy  out  1  high in every state except IDLE
- o_mem_req  out  1  one-cycle issue strobe to the controller
- o_mem_wr  out  1  1 = write
- o_mem_addr  out  ADDR_W  latched address
- o_mem_wdata  out  DATA_W  latched write data
- i_mem_wait  in  1  controller busy
- i_mem_rdata  in  DATA_W  controller read data

## Operation
- States: IDLE, ISSUE, GUARD, BUSY, DONE.
- **IDLE:** if any i_req is set, the picker selects the first asserted requester at or after rr_ptr (circular). On the clock edge the arbiter latches the winner index, wr, addr and wdata, sets rr_ptr = (winner+1) mod NUM_REQ, and goes to ISSUE. With no request it stays in IDLE.
- **ISSUE:** o_mem_req=1 and o_gnt[winner]=1 for exactly this cycle. Next state is GUARD.
- **GUARD:** i_mem_wait is ignored for one cycle, covering the controller's registered wait. Next state is BUSY.
- **BUSY:** stays while i_mem_wait=1. In the first cycle with i_mem_wait=0, i_mem_rdata is captured into o_rdata and the state goes to DONE.
- **Timeout:** a cycle counter is cleared on entering GUARD and counts in GUARD and BUSY. At TIMEOUT-1 the state goes to DONE with the error flag set, and o_rdata is forced to 0.
- **DONE:** o_done[winner]=1, and o_err=1 if the error flag is set. Next state is IDLE.
- o_mem_addr, o_mem_wdata and o_mem_wr stay stable from ISSUE through DONE. They change only on the IDLE→ISSUE edge.
- For writes, o_rdata is loaded from i_mem_rdata like any other transaction, and clients must ignore it.
- A client whose i_req drops before its grant is simply not served. No cancellation is possible after grant.
- A client re-requesting in the same cycle as its own o_done is arbitrated normally in the following IDLE cycle.
- Reset at any point: state IDLE, rr_ptr=0, counter=0, error flag 0. All outputs are 0, including o_mem_addr, o_mem_wdata and o_rdata. o_mem_req is never left asserted.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from i_req or i_mem_wait to any output.
- Minimum transaction length: i_req seen in cycle 0 → ISSUE in cycle 1 → GUARD in cycle 2 → BUSY in cycle 3 (wait already low) → DONE in cycle 4 → IDLE in cycle 5.
- Back-to-back issue interval is at least 5 cycles.
- Fairness: with all clients requesting continuously, grants rotate 0,1,…,NUM_REQ-1,0. No client waits more than NUM_REQ-1 foreign transactions.

## Structure
- Package sram_arb_pkg holds the state enum (arb_state_t), default ADDR_W/DATA_W constants and a clog2-based index-width helper.
- Sub-module rr_picker (combinational): inputs are the request vector and pointer. Outputs are a valid flag and the winner index. It is reusable for other shared resources.
- The top level holds the FSM, the latches, the timeout counter and the output decode.

## Test plan
- **Single read:** client 1 reads addr 0x0_1234; the controller model holds wait for 8 cycles and returns 0xBEEF. Required: o_gnt=3'b010 for 1 cycle, o_done=3'b010 with o_rdata=0xBEEF, o_err=0.
- **Rotation:** all 3 clients request continuously from reset. Grant order must be 0,1,2,0,1,2. No two o_mem_req pulses less than 5 cycles apart.
- **Pointer wrap:** after client 2 is served, only clients 2 and 0 request. Client 0 must win.
- **Timeout:** the model holds i_mem_wait=1 forever with TIMEOUT=16. Required: o_done and o_err assert exactly 16 cycles after GUARD entry, o_rdata=0, and the next request is served normally.
- **Immediate completion:** wait never rises. DONE must come 4 cycles after request; write data 0x00A5 must appear on o_mem_wdata from ISSUE through DONE.
- **Reset mid-BUSY:** asserting i_rst forces every output to 0 asynchronously. After release, the first grant goes to the lowest-indexed requester.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM client arbiter.
package sram_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 20;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GUARD,
      ST_BUSY,
      ST_DONE
   } arb_state_t;

   // Index width for n items; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid_c,
   output logic [IDX_W-1:0] idx_c
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid_c = 1'b0;
      idx_c   = '0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IDX_W'((32'(ptr) + k) % N);
         if (!valid_c && req[cand]) begin
            valid_c = 1'b1;
            idx_c   = cand;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port among NUM_REQ clients,
// one transaction at a time, with completion tracking and timeout abort.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ-1:0]        i_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
   input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic [NUM_REQ-1:0]        o_done,
   output logic                      o_err,
   output logic [DATA_W-1:0]         o_rdata,
   output logic                      o_busy,
   output logic                      o_mem_req,
   output logic                      o_mem_wr,
   output logic [ADDR_W-1:0]         o_mem_addr,
   output logic [DATA_W-1:0]         o_mem_wdata,
   input  logic                      i_mem_wait,
   input  logic [DATA_W-1:0]         i_mem_rdata
);

   localparam int unsigned IDX_W = idx_w(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   arb_state_t       state;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] rr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (i_req),
      .ptr     (rr_ptr),
      .valid_c (pick_valid),
      .idx_c   (pick_idx)
   );

   // FSM with registered outputs; o_err doubles as the timeout flag for the DONE cycle.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= ST_IDLE;
         win_idx     <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         o_gnt       <= '0;
         o_done      <= '0;
         o_err       <= 1'b0;
         o_rdata     <= '0;
         o_busy      <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_wr    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         o_gnt     <= '0;
         o_done    <= '0;
         o_err     <= 1'b0;
         o_mem_req <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state       <= ST_ISSUE;
                  win_idx     <= pick_idx;
                  rr_ptr      <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                  o_mem_wr    <= i_wr[pick_idx];
                  o_mem_addr  <= i_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
                  o_mem_wdata <= i_wdata[32'(pick_idx)*DATA_W +: DATA_W];
                  o_mem_req   <= 1'b1;
                  o_gnt       <= NUM_REQ'(1) << pick_idx;
                  o_busy      <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state <= ST_GUARD;
               cnt   <= '0;
            end
            // Controller wait is registered, so it is not trusted until BUSY.
            ST_GUARD: begin
               state <= ST_BUSY;
               cnt   <= cnt + CNT_W'(1);
            end
            ST_BUSY: begin
               if (!i_mem_wait) begin
                  state   <= ST_DONE;
                  o_rdata <= i_mem_rdata;
                  o_done  <= NUM_REQ'(1) << win_idx;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state   <= ST_DONE;
                  o_rdata <= '0;
                  o_err   <= 1'b1;
                  o_done  <= NUM_REQ'(1) << win_idx;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
